// File: rtl/instruction_execute.sv
// instruction_execute: EX stage of the 5-stage MIPS pipeline.
// Forwarded operand selection, ALU decode/execute and destination-register
// selection, all captured in the EX/MEM pipeline register (one-cycle latency).
// The register holds on halt, loads a bubble on flush and clears asynchronously on reset.
module instruction_execute #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_pcounter4,
    input  logic [NB_ADDR-1:0] i_rs,
    input  logic [NB_ADDR-1:0] i_rt,
    input  logic [NB_ADDR-1:0] i_rd,
    input  logic [NB_DATA-1:0] i_reg_DA,
    input  logic [NB_DATA-1:0] i_reg_DB,
    input  logic [NB_DATA-1:0] i_immediate,
    input  logic [5:0]         i_opcode,
    input  logic [5:0]         i_func,
    input  logic [4:0]         i_shamt,
    input  logic               i_regDst,
    input  logic               i_mem2Reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_aluSrc,
    input  logic [1:0]         i_aluOp,
    input  logic [1:0]         i_fwd_a,
    input  logic [1:0]         i_fwd_b,
    input  logic [NB_DATA-1:0] i_data_M,
    input  logic [NB_DATA-1:0] i_data_WB,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_DATA-1:0] o_write_data,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic               o_mem2Reg,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_regWrite
);
    localparam int NB_SH = $clog2(NB_DATA);

    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // EX/MEM pipeline payload
    typedef struct packed {
        logic [NB_DATA-1:0] alu_result;
        logic [NB_DATA-1:0] write_data;
        logic [NB_ADDR-1:0] wr_addr;
        logic               mem2reg;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
    } exmem_t;

    exmem_t             ex_d, ex_q;
    logic [NB_DATA-1:0] op_a, fwd_b, op_b, alu_res, pc_link;
    logic               is_jal, logic_imm;

    // rs only matters to the hazard/forwarding units upstream
    logic unused_rs;
    assign unused_rs = ^i_rs;

    assign pc_link   = i_pcounter4 + NB_DATA'(4);
    assign is_jal    = (i_opcode == OP_JAL);
    assign logic_imm = (i_opcode == OP_ANDI) || (i_opcode == OP_ORI) || (i_opcode == OP_XORI);

    // operand forwarding and B-operand source selection
    always_comb begin
        case (i_fwd_a)
            2'b01:   op_a = i_data_M;
            2'b10:   op_a = i_data_WB;
            default: op_a = i_reg_DA;
        endcase
        case (i_fwd_b)
            2'b01:   fwd_b = i_data_M;
            2'b10:   fwd_b = i_data_WB;
            default: fwd_b = i_reg_DB;
        endcase
        case (i_aluSrc)
            2'b01:   op_b = logic_imm ? NB_DATA'(i_immediate[15:0]) : i_immediate;
            2'b10:   op_b = NB_DATA'({i_immediate[15:0], 16'h0000});
            default: op_b = fwd_b;
        endcase
    end

    // ALU decode and execute
    always_comb begin
        alu_res = '0;
        case (i_aluOp)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (i_func)
                    6'b100000, 6'b100001: alu_res = op_a + op_b;
                    6'b100010, 6'b100011: alu_res = op_a - op_b;
                    6'b100100: alu_res = op_a & op_b;
                    6'b100101: alu_res = op_a | op_b;
                    6'b100110: alu_res = op_a ^ op_b;
                    6'b100111: alu_res = ~(op_a | op_b);
                    6'b101010: alu_res = NB_DATA'($signed(op_a) < $signed(op_b));
                    6'b101011: alu_res = NB_DATA'(op_a < op_b);
                    6'b000000: alu_res = op_b << i_shamt;
                    6'b000010: alu_res = op_b >> i_shamt;
                    6'b000011: alu_res = $unsigned($signed(op_b) >>> i_shamt);
                    6'b000100: alu_res = op_b << op_a[NB_SH-1:0];
                    6'b000110: alu_res = op_b >> op_a[NB_SH-1:0];
                    6'b000111: alu_res = $unsigned($signed(op_b) >>> op_a[NB_SH-1:0]);
                    6'b001001: alu_res = pc_link;
                    default:   alu_res = '0;
                endcase
            end
            default: begin
                case (i_opcode)
                    OP_ADDI, OP_ADDIU: alu_res = op_a + op_b;
                    OP_ANDI:  alu_res = op_a & op_b;
                    OP_ORI:   alu_res = op_a | op_b;
                    OP_XORI:  alu_res = op_a ^ op_b;
                    OP_LUI:   alu_res = op_b;
                    OP_SLTI:  alu_res = NB_DATA'($signed(op_a) < $signed(op_b));
                    OP_SLTIU: alu_res = NB_DATA'(op_a < op_b);
                    default:  alu_res = '0;
                endcase
            end
        endcase
    end

    // next EX/MEM contents; JAL links pc+8 into r31 regardless of ALU class
    always_comb begin
        ex_d            = '0;
        ex_d.alu_result = is_jal ? pc_link : alu_res;
        ex_d.write_data = fwd_b;
        ex_d.wr_addr    = is_jal ? NB_ADDR'(31) : (i_regDst ? i_rd : i_rt);
        ex_d.mem2reg    = i_mem2Reg;
        ex_d.mem_read   = i_memRead;
        ex_d.mem_write  = i_memWrite;
        ex_d.reg_write  = (is_jal || i_regWrite) && (ex_d.wr_addr != '0);
    end

    // EX/MEM register: halt holds, flush inserts a bubble
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)      ex_q <= '0;
        else if (i_halt)   ex_q <= ex_q;
        else if (i_flush)  ex_q <= '0;
        else               ex_q <= ex_d;
    end

    assign o_alu_result = ex_q.alu_result;
    assign o_write_data = ex_q.write_data;
    assign o_wr_addr    = ex_q.wr_addr;
    assign o_mem2Reg    = ex_q.mem2reg;
    assign o_memRead    = ex_q.mem_read;
    assign o_memWrite   = ex_q.mem_write;
    assign o_regWrite   = ex_q.reg_write;
endmodule

// File: tb/tb_instruction_execute.sv
// tb_instruction_execute: directed cases plus randomized traffic against a
// behavioural EX-stage model with halt/flush/reset tracking.
module tb_instruction_execute;
    typedef struct packed {
        logic [31:0] pc4, da, db, imm, dm, dwb;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  opc, func;
        logic [1:0]  alusrc, aluop, fa, fb;
        logic        regdst, m2r, mr, mw, rw;
    } tx_t;

    typedef struct packed {
        logic [31:0] alu, wd;
        logic [4:0]  wa;
        logic        m2r, mr, mw, rw;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halt = 1'b0;
    logic flush = 1'b0;
    tx_t  cur = '0;
    res_t exp_r = '0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] o_alu_result, o_write_data;
    logic [4:0]  o_wr_addr;
    logic        o_mem2Reg, o_memRead, o_memWrite, o_regWrite;

    always #5 clk = ~clk;

    instruction_execute dut (
        .clk(clk), .i_rst_n(rst_n), .i_halt(halt), .i_flush(flush),
        .i_pcounter4(cur.pc4), .i_rs(cur.rs), .i_rt(cur.rt), .i_rd(cur.rd),
        .i_reg_DA(cur.da), .i_reg_DB(cur.db), .i_immediate(cur.imm),
        .i_opcode(cur.opc), .i_func(cur.func), .i_shamt(cur.shamt),
        .i_regDst(cur.regdst), .i_mem2Reg(cur.m2r), .i_memRead(cur.mr),
        .i_memWrite(cur.mw), .i_regWrite(cur.rw), .i_aluSrc(cur.alusrc),
        .i_aluOp(cur.aluop), .i_fwd_a(cur.fa), .i_fwd_b(cur.fb),
        .i_data_M(cur.dm), .i_data_WB(cur.dwb),
        .o_alu_result(o_alu_result), .o_write_data(o_write_data), .o_wr_addr(o_wr_addr),
        .o_mem2Reg(o_mem2Reg), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
        .o_regWrite(o_regWrite)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // behavioural model: what the instruction means, not how the stage is built
    function automatic res_t ref_exec(input tx_t t);
        res_t        r;
        logic [31:0] a, b, bsrc, link;
        int          amt;
        a    = (t.fa == 2'd1) ? t.dm : (t.fa == 2'd2) ? t.dwb : t.da;
        b    = (t.fb == 2'd1) ? t.dm : (t.fb == 2'd2) ? t.dwb : t.db;
        link = t.pc4 + 32'd4;
        if (t.alusrc == 2'd1)
            bsrc = (t.opc inside {6'h0c, 6'h0d, 6'h0e}) ? {16'h0, t.imm[15:0]} : t.imm;
        else if (t.alusrc == 2'd2)
            bsrc = {t.imm[15:0], 16'h0};
        else
            bsrc = b;
        r = '0;
        if (t.aluop == 2'd0) r.alu = a + bsrc;
        else if (t.aluop == 2'd1) r.alu = a - bsrc;
        else if (t.aluop == 2'd2) begin
            amt = (t.func[2]) ? int'(a[4:0]) : int'(t.shamt);
            case (t.func)
                6'h20, 6'h21: r.alu = a + bsrc;
                6'h22, 6'h23: r.alu = a - bsrc;
                6'h24: r.alu = a & bsrc;
                6'h25: r.alu = a | bsrc;
                6'h26: r.alu = a ^ bsrc;
                6'h27: r.alu = ~(a | bsrc);
                6'h2a: r.alu = (int'(a) < int'(bsrc)) ? 32'd1 : 32'd0;
                6'h2b: r.alu = (longint'(a) < longint'(bsrc)) ? 32'd1 : 32'd0;
                6'h00, 6'h04: r.alu = 32'(longint'(bsrc) * (64'd1 << amt));
                6'h02, 6'h06: r.alu = 32'(longint'(bsrc) / (64'd1 << amt));
                // arithmetic shift = floor division of the signed value
                6'h03, 6'h07: r.alu = 32'(int'(bsrc) >>> amt);
                6'h09: r.alu = link;
                default: r.alu = 32'd0;
            endcase
        end else begin
            case (t.opc)
                6'h08, 6'h09: r.alu = a + bsrc;
                6'h0c: r.alu = a & bsrc;
                6'h0d: r.alu = a | bsrc;
                6'h0e: r.alu = a ^ bsrc;
                6'h0f: r.alu = bsrc;
                6'h0a: r.alu = (int'(a) < int'(bsrc)) ? 32'd1 : 32'd0;
                6'h0b: r.alu = (longint'(a) < longint'(bsrc)) ? 32'd1 : 32'd0;
                default: r.alu = 32'd0;
            endcase
        end
        r.wd  = b;
        r.wa  = t.regdst ? t.rd : t.rt;
        r.rw  = t.rw;
        if (t.opc == 6'h03) begin
            r.alu = link;
            r.wa  = 5'd31;
            r.rw  = 1'b1;
        end
        if (r.wa == 5'd0) r.rw = 1'b0;
        r.m2r = t.m2r;
        r.mr  = t.mr;
        r.mw  = t.mw;
        return r;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".alu"}, o_alu_result, exp_r.alu);
        chk({tag, ".wdata"}, o_write_data, exp_r.wd);
        chk({tag, ".waddr"}, 32'(o_wr_addr), 32'(exp_r.wa));
        chk({tag, ".ctrl"}, {28'h0, o_mem2Reg, o_memRead, o_memWrite, o_regWrite},
            {28'h0, exp_r.m2r, exp_r.mr, exp_r.mw, exp_r.rw});
    endtask

    // one clock: advance the model with the sampled inputs, then compare
    task automatic step(input string tag);
        @(posedge clk);
        if (!halt) exp_r = flush ? '0 : ref_exec(cur);
        #1 check_all(tag);
    endtask

    function automatic tx_t rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd);
        tx_t t = '0;
        t.aluop = 2'd2; t.func = f; t.da = a; t.db = b; t.regdst = 1'b1; t.rd = rd; t.rw = 1'b1;
        return t;
    endfunction

    logic [5:0] funcs [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] opcs [10] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h03, 6'h23};
    logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff, 32'h0000ffff};

    function automatic logic [31:0] rnd_data();
        if ($urandom_range(3) == 0) return edge_vals[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        tx_t t;
        // reset state
        #3 check_all("reset");
        chk("reset.alu_const", o_alu_result, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // ADDU
        cur = rtype(6'h21, 32'd5, 32'd7, 5'd3);
        step("addu");
        chk("addu.res", o_alu_result, 32'd12);
        chk("addu.wa", 32'(o_wr_addr), 32'd3);
        chk("addu.rw", 32'(o_regWrite), 32'd1);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 exp_r = '0;
        check_all("async_rst");
        chk("async_rst.alu", o_alu_result, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // ADDI with wrap-around
        t = '0; t.da = 32'hffffffff; t.imm = 32'd4; t.aluop = 2'd3; t.opc = 6'h08;
        t.alusrc = 2'd1; t.rt = 5'd2; t.rw = 1'b1; cur = t;
        step("addi");
        chk("addi.res", o_alu_result, 32'd3);
        chk("addi.wa", 32'(o_wr_addr), 32'd2);

        // forwarding into SUBU
        t = rtype(6'h23, 32'd99, 32'd98, 5'd4); t.fa = 2'd1; t.dm = 32'd10; t.fb = 2'd2; t.dwb = 32'd3;
        cur = t;
        step("fwd_subu");
        chk("fwd_subu.res", o_alu_result, 32'd7);
        // store takes forwarded B as data
        t = '0; t.da = 32'd100; t.imm = 32'd8; t.alusrc = 2'd1; t.fb = 2'd2; t.dwb = 32'd3;
        t.db = 32'd55; t.mw = 1'b1; cur = t;
        step("sw");
        chk("sw.wdata", o_write_data, 32'd3);
        chk("sw.addr", o_alu_result, 32'd108);

        // shifts and set-less-than
        t = rtype(6'h03, 32'd0, 32'h80000000, 5'd5); t.shamt = 5'd4; cur = t;
        step("sra");
        chk("sra.res", o_alu_result, 32'hf8000000);
        cur = rtype(6'h2a, 32'hffffffff, 32'd1, 5'd6);
        step("slt");
        chk("slt.res", o_alu_result, 32'd1);
        cur = rtype(6'h2b, 32'hffffffff, 32'd1, 5'd6);
        step("sltu");
        chk("sltu.res", o_alu_result, 32'd0);

        // JAL
        t = '0; t.opc = 6'h03; t.pc4 = 32'h40; t.rt = 5'd7; cur = t;
        step("jal");
        chk("jal.res", o_alu_result, 32'h44);
        chk("jal.wa", 32'(o_wr_addr), 32'd31);
        chk("jal.rw", 32'(o_regWrite), 32'd1);

        // write to r0 is suppressed
        cur = rtype(6'h21, 32'd1, 32'd2, 5'd0);
        step("r0");
        chk("r0.rw", 32'(o_regWrite), 32'd0);

        // halt holds for three cycles, then release loads
        cur = rtype(6'h21, 32'd5, 32'd7, 5'd3);
        step("pre_halt");
        halt = 1'b1;
        cur = rtype(6'h21, 32'd1, 32'd1, 5'd4);
        for (int i = 0; i < 3; i++) begin
            step("halt");
            chk("halt.res", o_alu_result, 32'd12);
        end
        halt = 1'b0;
        step("halt_rel");
        chk("halt_rel.res", o_alu_result, 32'd2);
        flush = 1'b1;
        step("flush");
        chk("flush.res", o_alu_result, 32'd0);
        chk("flush.rw", 32'(o_regWrite), 32'd0);
        flush = 1'b0;
        cur = rtype(6'h24, 32'hf0f0, 32'hff00, 5'd9);
        step("pre_hf");
        halt = 1'b1; flush = 1'b1;
        step("halt_flush");
        chk("halt_flush.res", o_alu_result, 32'hf000);
        halt = 1'b0; flush = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            t = '0;
            t.pc4 = $urandom & 32'hfffffffc;
            t.da = rnd_data(); t.db = rnd_data(); t.imm = rnd_data();
            t.dm = rnd_data(); t.dwb = rnd_data();
            t.rs = 5'($urandom); t.rt = 5'($urandom); t.rd = 5'($urandom);
            t.shamt = 5'($urandom);
            t.func = ($urandom_range(7) == 0) ? (($urandom_range(1) == 0) ? 6'h09 : 6'($urandom))
                                              : funcs[$urandom_range(15)];
            t.opc = ($urandom_range(9) == 0) ? 6'($urandom) : opcs[$urandom_range(9)];
            if (t.opc == 6'h03 && $urandom_range(1) == 0) t.opc = 6'h00;
            t.alusrc = 2'($urandom); t.aluop = 2'($urandom);
            t.fa = 2'($urandom); t.fb = 2'($urandom);
            t.regdst = 1'($urandom); t.m2r = 1'($urandom); t.mr = 1'($urandom);
            t.mw = 1'($urandom); t.rw = 1'($urandom);
            cur = t;
            halt  = ($urandom_range(9) == 0);
            flush = ($urandom_range(9) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
